// File: rtl/bus_slave_bridge_pkg.sv
// Shared definitions for the bus-slave bridge.
//   state_t         : bridge FSM state encoding
//   BUS_MODE_READ   : BUS_mode value for a read request
//   BUS_MODE_WRITE  : BUS_mode value for a write request
package bus_slave_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WACK   = 3'd1,
        ST_RDRAIN = 3'd2,
        ST_RREQ   = 3'd3,
        ST_RRESP  = 3'd4
    } state_t;

    localparam logic BUS_MODE_READ  = 1'b0;
    localparam logic BUS_MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_slave_bridge_if.sv
// System-bus side of the bridge.
//   BUS_valid/BUS_mode/BUS_addr/BUS_wdata : request, held by master until completion
//   BUS_wready                            : one-cycle write-accept pulse
//   BUS_rvalid/BUS_rdata/BUS_rready       : read response, held until taken
// Modports: master (drives requests), slave (the bridge).
interface bus_slave_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  BUS_valid;
    logic                  BUS_mode;
    logic [ADDR_WIDTH-1:0] BUS_addr;
    logic [DATA_WIDTH-1:0] BUS_wdata;
    logic                  BUS_wready;
    logic                  BUS_rvalid;
    logic                  BUS_rready;
    logic [DATA_WIDTH-1:0] BUS_rdata;

    modport master (
        output BUS_valid, BUS_mode, BUS_addr, BUS_wdata, BUS_rready,
        input  BUS_wready, BUS_rvalid, BUS_rdata
    );

    modport slave (
        input  BUS_valid, BUS_mode, BUS_addr, BUS_wdata, BUS_rready,
        output BUS_wready, BUS_rvalid, BUS_rdata
    );
endinterface

// File: rtl/bus_slave_bridge_wfifo.sv
// bus_wfifo: synchronous FIFO holding posted writes {addr, data}.
//   push_i/din_i : write an entry (ignored when full)
//   pop_i/dout_o : dout_o is the head entry; pop_i removes it (ignored when empty)
//   full_o, empty_o, level_o : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module bus_wfifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A full FIFO rejects a push even if it is popped in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/bus_slave_bridge.sv
// bus_slave_bridge: system-bus slave for one address window, translating to a
// window-relative device address. Writes are posted through bus_wfifo; reads
// wait until every posted write has drained, then hold the response until taken.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : bus_slave_bridge_if.slave (system bus side)
//   write_en/write_ready, read_en/read_valid, addr, wdata, rdata : device port
//   wfifo_level    : posted writes outstanding
// Optional macro BUS_SLAVE_TIMEOUT_EN: a device read not answered within TIMEOUT
// cycles completes with TIMEOUT_DATA.
module bus_slave_bridge
    import bus_slave_bridge_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0001_0000,
    parameter logic [ADDR_WIDTH-1:0] WIN_SIZE    = 'h0001_0000,
    parameter int                    WFIFO_DEPTH = 4
`ifdef BUS_SLAVE_TIMEOUT_EN
   ,parameter int                    TIMEOUT      = 256,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 'hDEAD_BEEF
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bus_slave_bridge_if.slave            bus,
    output logic                         write_en,
    input  logic                         write_ready,
    output logic                         read_en,
    input  logic                         read_valid,
    output logic [ADDR_WIDTH-1:0]        addr,
    output logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH-1:0]        rdata,
    output logic [$clog2(WFIFO_DEPTH):0] wfifo_level
);
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    state_t          state_q, state_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   bus_off;
    logic            bus_hit;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW+DW-1:0] fifo_dout;

    // Offset compare keeps the window end from overflowing at the top of the map.
    assign bus_off = bus.BUS_addr - BASE_ADDR;
    assign bus_hit = bus.BUS_valid && (bus_off < WIN_SIZE);

    bus_wfifo #(.WIDTH(AW + DW), .DEPTH(WFIFO_DEPTH)) u_wfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   ({bus_off, bus.BUS_wdata}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (wfifo_level)
    );

`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        fifo_push = 1'b0;
`ifdef BUS_SLAVE_TIMEOUT_EN
        cnt_d     = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus_hit) begin
                    if (bus.BUS_mode == BUS_MODE_WRITE) begin
                        if (!fifo_full) begin
                            fifo_push = 1'b1;
                            state_d   = ST_WACK;
                        end
                    end else begin
                        raddr_d = bus_off;
                        state_d = fifo_empty ? ST_RREQ : ST_RDRAIN;
                    end
                end
            end
            ST_WACK:   state_d = ST_IDLE;
            ST_RDRAIN: if (fifo_empty) state_d = ST_RREQ;
            ST_RREQ: begin
                if (read_valid) begin
                    rdata_d = rdata;
                    state_d = ST_RRESP;
                end
`ifdef BUS_SLAVE_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = TIMEOUT_DATA;
                    state_d = ST_RRESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            ST_RRESP:  if (bus.BUS_rready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The device port carries a read only in RREQ, when the FIFO is known empty.
    assign write_en       = !fifo_empty && (state_q != ST_RREQ);
    assign fifo_pop       = write_en && write_ready;
    assign read_en        = (state_q == ST_RREQ);
    assign addr           = write_en ? fifo_dout[AW+DW-1:DW] : (read_en ? raddr_q : '0);
    assign wdata          = write_en ? fifo_dout[DW-1:0] : '0;
    assign bus.BUS_wready = (state_q == ST_WACK);
    assign bus.BUS_rvalid = (state_q == ST_RRESP);
    assign bus.BUS_rdata  = rdata_q;

endmodule

// File: tb/tb_bus_slave_bridge.sv
module tb_bus_slave_bridge;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] WIN  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_ready = 1'b0;
    logic        read_valid = 1'b0;
    logic [31:0] rdata = '0;
    logic        write_en, read_en;
    logic [31:0] addr, wdata;
    logic [2:0]  wfifo_level;

    bus_slave_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    bus_slave_bridge dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .write_en    (write_en),
        .write_ready (write_ready),
        .read_en     (read_en),
        .read_valid  (read_valid),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .wfifo_level (wfifo_level)
    );

    always #5 clk = ~clk;

    typedef logic [63:0] ent_t;
    ent_t exp_q[$];
    ent_t obs_q[$];
    int   total = 0;
    int   bad = 0;
    int   viol = 0;
    bit   rand_wr = 1'b0;

    // Device-side observer: records every accepted device write.
    always @(posedge clk) begin
        if (rst_n) begin
            if (write_en && read_en) viol++;
            if (write_en && write_ready) obs_q.push_back({addr, wdata});
        end
    end

    function automatic bit model_hit(input logic [31:0] a);
        longint unsigned la;
        la = 64'(a);
        return (la >= 64'(BASE)) && (la <= 64'(BASE) + 64'(WIN) - 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_wr) write_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_level(input string tag);
        chk(tag, 64'(wfifo_level), 64'(exp_q.size() - obs_q.size()));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wready"}, 64'(bus.BUS_wready), 64'(0));
        chk({tag, "_rvalid"}, 64'(bus.BUS_rvalid), 64'(0));
        chk({tag, "_rdata"},  64'(bus.BUS_rdata),  64'(0));
        chk({tag, "_wen"},    64'(write_en),       64'(0));
        chk({tag, "_ren"},    64'(read_en),        64'(0));
        chk({tag, "_addr"},   64'(addr),           64'(0));
        chk({tag, "_wdata"},  64'(wdata),          64'(0));
        chk({tag, "_level"},  64'(wfifo_level),    64'(0));
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input int max_wait, output bit acked);
        acked = 1'b0;
        bus.BUS_valid = 1'b1;
        bus.BUS_mode  = 1'b1;
        bus.BUS_addr  = a;
        bus.BUS_wdata = d;
        for (int n = 0; n < max_wait; n++) begin
            tick();
            if (bus.BUS_wready) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) begin
            exp_q.push_back({a - BASE, d});
            bus.BUS_valid = 1'b0;
            chk_level("wr_level");
            tick();
            chk("wready_pulse", 64'(bus.BUS_wready), 64'(0));
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bit acked;
        bus_write(a, d, 30, acked);
        chk("wr_ack", 64'(acked), 64'(model_hit(a)));
        if (!acked) begin
            bus.BUS_valid = 1'b0;
            chk_level("miss_level");
            tick();
        end
    endtask

    task automatic bus_read(input logic [31:0] a, input int rd_delay, input int rr_delay,
                            input int exp_lat);
        logic [31:0] v;
        int lat;
        bit seen;
        v = $urandom;
        lat = 0;
        seen = 1'b0;
        bus.BUS_valid  = 1'b1;
        bus.BUS_mode   = 1'b0;
        bus.BUS_addr   = a;
        bus.BUS_rready = 1'b0;
        for (int n = 0; n < (model_hit(a) ? 60 : 12); n++) begin
            tick();
            lat++;
            if (read_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!model_hit(a)) begin
            chk("miss_rd_en", 64'(seen), 64'(0));
            chk("miss_rvalid", 64'(bus.BUS_rvalid), 64'(0));
            bus.BUS_valid = 1'b0;
            tick();
            return;
        end
        chk("rd_en_seen", 64'(seen), 64'(1));
        if (!seen) begin
            bus.BUS_valid = 1'b0;
            return;
        end
        chk("rd_order", 64'(obs_q.size()), 64'(exp_q.size()));
        chk("rd_addr", 64'(addr), 64'(a - BASE));
        for (int i = 0; i < rd_delay; i++) begin
            tick();
            lat++;
            chk("rd_en_hold", 64'(read_en), 64'(1));
        end
        read_valid = 1'b1;
        rdata = v;
        tick();
        lat++;
        read_valid = 1'b0;
        rdata = $urandom;
        chk("rvalid", 64'(bus.BUS_rvalid), 64'(1));
        chk("rdata", 64'(bus.BUS_rdata), 64'(v));
        chk("rd_en_drop", 64'(read_en), 64'(0));
        if (exp_lat != 0) chk("rd_lat", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < rr_delay; i++) begin
            tick();
            chk("rvalid_hold", 64'(bus.BUS_rvalid), 64'(1));
            chk("rdata_hold", 64'(bus.BUS_rdata), 64'(v));
        end
        bus.BUS_rready = 1'b1;
        bus.BUS_valid  = 1'b0;
        tick();
        bus.BUS_rready = 1'b0;
        chk("rvalid_done", 64'(bus.BUS_rvalid), 64'(0));
    endtask

    task automatic check_drain(input string tag);
        int m;
        for (int n = 0; n < 100; n++) begin
            if (wfifo_level == 0) break;
            tick();
        end
        chk({tag, "_level"}, 64'(wfifo_level), 64'(0));
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk({tag, "_entry"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return BASE + $urandom_range(0, 32'h0000_FFFF);
            1:       return BASE - 1 - $urandom_range(0, 15);
            2:       return BASE + WIN + $urandom_range(0, 15);
            3:       return BASE;
            4:       return BASE + WIN - 1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit acked;
        bus.BUS_valid  = 1'b0;
        bus.BUS_mode   = 1'b0;
        bus.BUS_addr   = '0;
        bus.BUS_wdata  = '0;
        bus.BUS_rready = 1'b0;

        // reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // single write, immediate device accept
        write_ready = 1'b1;
        bus.BUS_valid = 1'b1;
        bus.BUS_mode  = 1'b1;
        bus.BUS_addr  = 32'h0001_0010;
        bus.BUS_wdata = 32'hA5A5_A5A5;
        tick();
        chk("t1_wready", 64'(bus.BUS_wready), 64'(1));
        chk("t1_wen", 64'(write_en), 64'(1));
        chk("t1_addr", 64'(addr), 64'h10);
        chk("t1_wdata", 64'(wdata), 64'hA5A5_A5A5);
        exp_q.push_back({32'h10, 32'hA5A5_A5A5});
        bus.BUS_valid = 1'b0;
        tick();
        chk("t1_wready_pulse", 64'(bus.BUS_wready), 64'(0));
        chk("t1_wen_done", 64'(write_en), 64'(0));
        check_drain("t1");

        // FIFO fill with stalled device, fifth write waits
        write_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_write(BASE + 32'(i * 4), $urandom);
        chk("t2_level4", 64'(wfifo_level), 64'(4));
        bus_write(BASE + 32'h40, 32'h5555_0005, 6, acked);
        chk("t2_stall", 64'(acked), 64'(0));
        chk("t2_stall_level", 64'(wfifo_level), 64'(4));
        chk("t2_head_addr", 64'(addr), 64'(0));
        write_ready = 1'b1;
        bus_write(BASE + 32'h40, 32'h5555_0005, 20, acked);
        chk("t2_release", 64'(acked), 64'(1));
        check_drain("t2");

        // read ordered behind posted writes
        write_ready = 1'b0;
        do_write(BASE + 32'h100, 32'h1111_1111);
        do_write(BASE + 32'h104, 32'h2222_2222);
        bus.BUS_valid = 1'b1;
        bus.BUS_mode  = 1'b0;
        bus.BUS_addr  = 32'h0001_0020;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_rd_blocked", 64'(read_en), 64'(0));
        end
        rand_wr = 1'b1;
        bus_read(32'h0001_0020, 1, 0, 0);
        rand_wr = 1'b0;
        write_ready = 1'b1;
        check_drain("t3");

        // immediate read latency and held response
        bus_read(32'h0001_0200, 0, 3, 2);
        bus_read(32'h0001_0204, 2, 0, 0);

        // window boundaries
        do_write(32'h0000_FFFF, 32'hBAD0_0001);
        do_write(32'h0002_0000, 32'hBAD0_0002);
        bus_read(32'h0000_FFFF, 0, 0, 0);
        bus_read(32'h0002_0000, 0, 0, 0);
        do_write(32'h0001_FFFF, 32'h600D_0001);
        bus_read(32'h0001_FFFF, 0, 1, 2);
        check_drain("t5");

        // reset with posted writes pending and a read waiting behind them
        write_ready = 1'b0;
        do_write(BASE + 32'h300, 32'h3333_0000);
        do_write(BASE + 32'h304, 32'h3333_0001);
        bus.BUS_valid = 1'b1;
        bus.BUS_mode  = 1'b0;
        bus.BUS_addr  = BASE + 32'h308;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6");
        bus.BUS_valid = 1'b0;
        obs_q.delete();
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        write_ready = 1'b1;
        tick();
        do_write(BASE + 32'h400, 32'h4444_4444);
        check_drain("t6_after");

`ifdef BUS_SLAVE_TIMEOUT_EN
        begin
            int lat;
            lat = 0;
            bus.BUS_valid  = 1'b1;
            bus.BUS_mode   = 1'b0;
            bus.BUS_addr   = BASE + 32'h500;
            bus.BUS_rready = 1'b0;
            for (int n = 0; n < 400; n++) begin
                tick();
                lat++;
                if (bus.BUS_rvalid) break;
            end
            chk("to_rvalid", 64'(bus.BUS_rvalid), 64'(1));
            chk("to_lat", 64'(lat), 64'(257));
            chk("to_rdata", 64'(bus.BUS_rdata), 64'hDEAD_BEEF);
            chk("to_rd_en", 64'(read_en), 64'(0));
            bus.BUS_rready = 1'b1;
            bus.BUS_valid  = 1'b0;
            tick();
            bus.BUS_rready = 1'b0;
            chk("to_done", 64'(bus.BUS_rvalid), 64'(0));
        end
`endif

        // randomized traffic against the reference model
        rand_wr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = pick_addr();
            if ($urandom_range(0, 2) != 0) do_write(a, $urandom);
            else bus_read(a, $urandom_range(0, 3), $urandom_range(0, 2), 0);
        end
        check_drain("rand");
        rand_wr = 1'b0;

        chk("port_exclusive", 64'(viol), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
